// File: rtl/stack_call_sequencer_if.sv
// Stack memory port between the call/return sequencer and the stack RAM.
interface stack_call_sequencer_if #(
    parameter int unsigned SP_W = 20
) ();
    logic            mem_req;
    logic            mem_we;
    logic [SP_W-1:0] mem_addr;
    logic [15:0]     mem_wdata;
    logic [15:0]     mem_rdata;
    logic            mem_ack;

    // Sequencer side issues requests, memory side acknowledges.
    modport master (
        output mem_req, mem_we, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_we, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/stack_call_sequencer.sv
// CALL / RET / RETI / interrupt-entry sequencer: saves and restores PC and flags
// through a 16-bit downward-growing stack, then redirects the PC.
module stack_call_sequencer #(
    parameter int unsigned     SP_W    = 20,
    parameter logic [SP_W-1:0] SP_INIT = SP_W'(20'hFFFFF),
    parameter logic [31:0]     INT_VEC = 32'h0000_0010
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [4:0]               opcode,
    input  logic                     op_valid,
    input  logic                     kill,
    input  logic [31:0]              call_target,
    input  logic [31:0]              call_ret_pc,
    input  logic [31:0]              int_ret_pc,
    input  logic [2:0]               flags_in,
    input  logic                     int_req,
    stack_call_sequencer_if.master   mem,
    output logic                     stall,
    output logic                     flush,
    output logic                     pc_load,
    output logic [31:0]              pc_value,
    output logic                     flags_load,
    output logic [2:0]               flags_value,
    output logic                     int_ack,
    output logic                     int_en,
    output logic [SP_W-1:0]          sp
);
    localparam logic [4:0] OP_CALL = 5'd20;
    localparam logic [4:0] OP_RET  = 5'd21;
    localparam logic [4:0] OP_RETI = 5'd22;

    typedef enum logic [2:0] {
        S_IDLE, S_PUSH_F, S_PUSH_HI, S_PUSH_LO, S_POP_LO, S_POP_HI, S_POP_F, S_LOAD
    } state_e;

    typedef enum logic [1:0] { K_CALL, K_INT, K_RET, K_RETI } kind_e;

    state_e          state_q, state_d;
    kind_e           kind_q, kind_d;
    logic [SP_W-1:0] sp_q, sp_d;
    logic [31:0]     ret_q, ret_d;      // PC being pushed, or PC being popped
    logic [31:0]     tgt_q, tgt_d;
    logic [2:0]      flg_q, flg_d;      // flags being pushed, or flags being popped
    logic            int_en_q, int_en_d;

    logic            mem_req_q, mem_req_d;
    logic            mem_we_q, mem_we_d;
    logic [SP_W-1:0] mem_addr_q, mem_addr_d;
    logic [15:0]     mem_wdata_q, mem_wdata_d;
    logic            stall_q, stall_d;
    logic            flush_q, flush_d;
    logic            pc_load_q, pc_load_d;
    logic [31:0]     pc_value_q, pc_value_d;
    logic            flags_load_q, flags_load_d;
    logic [2:0]      flags_value_q, flags_value_d;
    logic            int_ack_q, int_ack_d;
    logic            is_push, is_pop, is_load;

    // Next-state, stack pointer and operand capture, then registered-output values
    // derived from the next state so every output changes on the same edge as state.
    always_comb begin
        state_d  = state_q;
        kind_d   = kind_q;
        sp_d     = sp_q;
        ret_d    = ret_q;
        tgt_d    = tgt_q;
        flg_d    = flg_q;
        int_en_d = int_en_q;

        case (state_q)
            S_IDLE: begin
                if (int_req && int_en_q) begin
                    state_d  = S_PUSH_F;
                    kind_d   = K_INT;
                    ret_d    = int_ret_pc;
                    tgt_d    = INT_VEC;
                    flg_d    = flags_in;
                    int_en_d = 1'b0;
                end else if (op_valid && !kill) begin
                    case (opcode)
                        OP_CALL: begin
                            state_d = S_PUSH_HI;
                            kind_d  = K_CALL;
                            ret_d   = call_ret_pc;
                            tgt_d   = call_target;
                        end
                        OP_RET: begin
                            state_d = S_POP_LO;
                            kind_d  = K_RET;
                        end
                        OP_RETI: begin
                            state_d = S_POP_LO;
                            kind_d  = K_RETI;
                        end
                        default: ;
                    endcase
                end
            end
            S_PUSH_F: begin
                if (mem.mem_ack) begin
                    sp_d    = sp_q - SP_W'(1);
                    state_d = S_PUSH_HI;
                end
            end
            S_PUSH_HI: begin
                if (mem.mem_ack) begin
                    sp_d    = sp_q - SP_W'(1);
                    state_d = S_PUSH_LO;
                end
            end
            S_PUSH_LO: begin
                if (mem.mem_ack) begin
                    sp_d    = sp_q - SP_W'(1);
                    state_d = S_LOAD;
                end
            end
            S_POP_LO: begin
                if (mem.mem_ack) begin
                    sp_d        = sp_q + SP_W'(1);
                    ret_d[15:0] = mem.mem_rdata;
                    state_d     = S_POP_HI;
                end
            end
            S_POP_HI: begin
                if (mem.mem_ack) begin
                    sp_d         = sp_q + SP_W'(1);
                    ret_d[31:16] = mem.mem_rdata;
                    state_d      = (kind_q == K_RETI) ? S_POP_F : S_LOAD;
                end
            end
            S_POP_F: begin
                if (mem.mem_ack) begin
                    sp_d    = sp_q + SP_W'(1);
                    flg_d   = mem.mem_rdata[2:0];
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                state_d = S_IDLE;
                if (kind_q == K_RETI) begin
                    int_en_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase

        is_push = (state_d == S_PUSH_F) || (state_d == S_PUSH_HI) || (state_d == S_PUSH_LO);
        is_pop  = (state_d == S_POP_LO) || (state_d == S_POP_HI) || (state_d == S_POP_F);
        is_load = (state_d == S_LOAD);

        mem_req_d  = is_push || is_pop;
        mem_we_d   = is_push;
        mem_addr_d = is_pop ? (sp_d + SP_W'(1)) : sp_d;
        case (state_d)
            S_PUSH_F:  mem_wdata_d = {13'b0, flg_d};
            S_PUSH_HI: mem_wdata_d = ret_d[31:16];
            S_PUSH_LO: mem_wdata_d = ret_d[15:0];
            default:   mem_wdata_d = 16'h0000;
        endcase

        stall_d       = (state_d != S_IDLE);
        pc_load_d     = is_load;
        flush_d       = is_load;
        pc_value_d    = pc_value_q;
        if (is_load) begin
            pc_value_d = ((kind_d == K_CALL) || (kind_d == K_INT)) ? tgt_d : ret_d;
        end
        flags_load_d  = is_load && (kind_d == K_RETI);
        flags_value_d = flags_load_d ? flg_d : flags_value_q;
        int_ack_d     = is_load && (kind_d == K_INT);
    end

    // State, datapath and output registers; reset abandons any access in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= S_IDLE;
            kind_q        <= K_CALL;
            sp_q          <= SP_INIT;
            ret_q         <= 32'h0;
            tgt_q         <= 32'h0;
            flg_q         <= 3'b000;
            int_en_q      <= 1'b1;
            mem_req_q     <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= 16'h0000;
            stall_q       <= 1'b0;
            flush_q       <= 1'b0;
            pc_load_q     <= 1'b0;
            pc_value_q    <= 32'h0;
            flags_load_q  <= 1'b0;
            flags_value_q <= 3'b000;
            int_ack_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            kind_q        <= kind_d;
            sp_q          <= sp_d;
            ret_q         <= ret_d;
            tgt_q         <= tgt_d;
            flg_q         <= flg_d;
            int_en_q      <= int_en_d;
            mem_req_q     <= mem_req_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            stall_q       <= stall_d;
            flush_q       <= flush_d;
            pc_load_q     <= pc_load_d;
            pc_value_q    <= pc_value_d;
            flags_load_q  <= flags_load_d;
            flags_value_q <= flags_value_d;
            int_ack_q     <= int_ack_d;
        end
    end

    assign mem.mem_req   = mem_req_q;
    assign mem.mem_we    = mem_we_q;
    assign mem.mem_addr  = mem_addr_q;
    assign mem.mem_wdata = mem_wdata_q;
    assign stall         = stall_q;
    assign flush         = flush_q;
    assign pc_load       = pc_load_q;
    assign pc_value      = pc_value_q;
    assign flags_load    = flags_load_q;
    assign flags_value   = flags_value_q;
    assign int_ack       = int_ack_q;
    assign int_en        = int_en_q;
    assign sp            = sp_q;
endmodule

// File: tb/tb_stack_call_sequencer.sv
// Self-checking bench for stack_call_sequencer: a stack RAM responder with
// configurable ack latency, and a behavioural stack model predicting accesses,
// PC/flags redirects, stall length, sp and int_en.
module tb_stack_call_sequencer;
    localparam int unsigned SP_W    = 20;
    localparam logic [19:0] SP_INIT = 20'hFFFFF;
    localparam logic [31:0] INT_VEC = 32'h0000_0010;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [4:0]  opcode = 5'd0;
    logic        op_valid = 1'b0;
    logic        kill = 1'b0;
    logic [31:0] call_target = 32'h0;
    logic [31:0] call_ret_pc = 32'h0;
    logic [31:0] int_ret_pc = 32'h0;
    logic [2:0]  flags_in = 3'b000;
    logic        int_req = 1'b0;
    logic        stall, flush, pc_load, flags_load, int_ack, int_en;
    logic [31:0] pc_value;
    logic [2:0]  flags_value;
    logic [19:0] sp;

    stack_call_sequencer_if #(.SP_W(SP_W)) bus ();

    stack_call_sequencer #(.SP_W(SP_W), .SP_INIT(SP_INIT), .INT_VEC(INT_VEC)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .op_valid(op_valid), .kill(kill),
        .call_target(call_target), .call_ret_pc(call_ret_pc), .int_ret_pc(int_ret_pc),
        .flags_in(flags_in), .int_req(int_req), .mem(bus),
        .stall(stall), .flush(flush), .pc_load(pc_load), .pc_value(pc_value),
        .flags_load(flags_load), .flags_value(flags_value), .int_ack(int_ack),
        .int_en(int_en), .sp(sp)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;

    typedef struct packed {
        logic [19:0] addr;
        logic        we;
        logic [15:0] data;
    } acc_t;

    // Stack RAM seen by the responder, and the log of completed accesses.
    logic [15:0] mem_arr [int];
    acc_t        acc_log [$];
    int          ack_delay = 0;
    bit          spur_en = 1'b0;
    int          unstable = 0;

    function automatic logic [15:0] fill_word(input logic [19:0] a);
        return a[15:0] ^ 16'hC3A5;
    endfunction

    // Memory responder: acks after ack_delay waiting cycles, checks request stability.
    initial begin : responder
        int waited;
        logic [19:0] pa;
        logic [15:0] pd;
        logic pw;
        acc_t e;
        waited = 0; pa = '0; pd = '0; pw = 1'b0;
        bus.mem_ack = 1'b0;
        bus.mem_rdata = 16'h0;
        forever begin
            @(negedge clk);
            bus.mem_ack = 1'b0;
            bus.mem_rdata = 16'($urandom);
            if (bus.mem_req) begin
                if (waited > 0 && (bus.mem_addr !== pa || bus.mem_we !== pw ||
                                   (pw && bus.mem_wdata !== pd))) unstable++;
                pa = bus.mem_addr; pw = bus.mem_we; pd = bus.mem_wdata;
                if (waited >= ack_delay) begin
                    bus.mem_ack = 1'b1;
                    e.addr = bus.mem_addr;
                    e.we   = bus.mem_we;
                    e.data = bus.mem_we ? bus.mem_wdata : 16'h0;
                    if (bus.mem_we) mem_arr[int'(bus.mem_addr)] = bus.mem_wdata;
                    else bus.mem_rdata = mem_arr.exists(int'(bus.mem_addr)) ?
                                         mem_arr[int'(bus.mem_addr)] : fill_word(bus.mem_addr);
                    acc_log.push_back(e);
                    waited = 0;
                end else begin
                    waited++;
                end
            end else begin
                waited = 0;
                if (spur_en) bus.mem_ack = 1'($urandom_range(0, 1));
            end
        end
    end

    // Behavioural model: stack words, stack pointer and interrupt enable.
    logic [19:0] m_sp = SP_INIT;
    bit          m_int_en = 1'b1;
    logic [15:0] m_mem [int];
    acc_t        exp_log [$];
    bit          e_acc, e_fload, e_iack;
    logic [31:0] e_pc;
    logic [2:0]  e_flags;
    int          e_busy;

    task automatic m_push(input logic [15:0] w);
        acc_t e;
        e.addr = m_sp; e.we = 1'b1; e.data = w;
        exp_log.push_back(e);
        m_mem[int'(m_sp)] = w;
        m_sp = m_sp - 20'd1;
    endtask

    task automatic m_pop(output logic [15:0] w);
        acc_t e;
        logic [19:0] a;
        a = m_sp + 20'd1;
        e.addr = a; e.we = 1'b0; e.data = 16'h0;
        exp_log.push_back(e);
        w = m_mem.exists(int'(a)) ? m_mem[int'(a)] : fill_word(a);
        m_sp = a;
    endtask

    task automatic model_op(input logic [4:0] op, input bit valid, input bit kl, input bit irq,
                            input logic [31:0] tgt, input logic [31:0] ret,
                            input logic [31:0] iret, input logic [2:0] fl);
        logic [15:0] lo, hi, fw;
        exp_log.delete();
        e_acc = 1'b0; e_fload = 1'b0; e_iack = 1'b0; e_pc = 32'h0; e_flags = 3'b000;
        if (irq && m_int_en) begin
            m_push({13'b0, fl}); m_push(iret[31:16]); m_push(iret[15:0]);
            e_pc = INT_VEC; e_iack = 1'b1; m_int_en = 1'b0; e_acc = 1'b1;
        end else if (valid && !kl && op == 5'd20) begin
            m_push(ret[31:16]); m_push(ret[15:0]);
            e_pc = tgt; e_acc = 1'b1;
        end else if (valid && !kl && (op == 5'd21 || op == 5'd22)) begin
            m_pop(lo); m_pop(hi);
            e_pc = {hi, lo};
            if (op == 5'd22) begin
                m_pop(fw); e_flags = fw[2:0]; e_fload = 1'b1; m_int_en = 1'b1;
            end
            e_acc = 1'b1;
        end
        e_busy = e_acc ? (exp_log.size() * (ack_delay + 1) + 1) : 0;
    endtask

    // Drive one decode-slot request, then scramble operands so late changes are exercised.
    task automatic issue(input logic [4:0] op, input bit valid, input bit kl, input bit irq,
                         input logic [31:0] tgt, input logic [31:0] ret,
                         input logic [31:0] iret, input logic [2:0] fl);
        acc_log.delete();
        @(negedge clk);
        opcode = op; op_valid = valid; kill = kl; int_req = irq;
        call_target = tgt; call_ret_pc = ret; int_ret_pc = iret; flags_in = fl;
        @(posedge clk);
        #1;
        op_valid = 1'b0; kill = 1'b0; int_req = 1'b0;
        opcode = 5'($urandom); call_target = $urandom; call_ret_pc = $urandom;
        int_ret_pc = $urandom; flags_in = 3'($urandom);
    endtask

    // Watch the busy window until stall drops (bounded), collecting strobes.
    task automatic observe(output int busy, output int n_load, output logic [31:0] pcv,
                           output int n_fl, output logic [2:0] flv, output int n_ack,
                           output int fmis, output bit timeout);
        bit done;
        busy = 0; n_load = 0; pcv = 32'h0; n_fl = 0; flv = 3'b000; n_ack = 0; fmis = 0;
        done = 1'b0;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            if (!stall) begin done = 1'b1; break; end
            busy++;
            if (pc_load) begin n_load++; pcv = pc_value; end
            if (flags_load) begin n_fl++; flv = flags_value; end
            if (int_ack) n_ack++;
            if (flush !== pc_load) fmis++;
        end
        timeout = !done;
    endtask

    int busy, n_load, n_fl, n_ack, fmis;
    logic [31:0] pcv;
    logic [2:0] flv;
    bit tmo;

    task automatic test_reset();
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req: got %b want 0", bus.mem_req); end
        n_cmp++; if (stall !== 1'b0) begin n_fail++; $display("FAIL rst_stall: got %b want 0", stall); end
        n_cmp++; if (sp !== SP_INIT) begin n_fail++; $display("FAIL rst_sp: got %h want %h", sp, SP_INIT); end
        n_cmp++; if (int_en !== 1'b1) begin n_fail++; $display("FAIL rst_int_en: got %b want 1", int_en); end
        n_cmp++; if ({pc_load, flush, flags_load, int_ack} !== 4'b0) begin n_fail++; $display("FAIL rst_strobes: got %b want 0000", {pc_load, flush, flags_load, int_ack}); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        m_sp = SP_INIT; m_int_en = 1'b1;
    endtask

    task automatic test_call_ret();
        acc_t want [2];
        ack_delay = 0;
        model_op(5'd20, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h0001_0004, 32'h0, 3'b000);
        issue(5'd20, 1'b1, 1'b0, 1'b0, 32'h0000_0200, 32'h0001_0004, 32'h0, 3'b000);
        observe(busy, n_load, pcv, n_fl, flv, n_ack, fmis, tmo);
        want[0] = {20'hFFFFF, 1'b1, 16'h0001};
        want[1] = {20'hFFFFE, 1'b1, 16'h0004};
        n_cmp++; if (acc_log.size() != 2) begin n_fail++; $display("FAIL call_nacc: got %0d want 2", acc_log.size()); end
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (i >= acc_log.size() || acc_log[i] !== want[i]) begin n_fail++; $display("FAIL call_acc%0d: got %h want %h", i, (i < acc_log.size()) ? acc_log[i] : '0, want[i]); end
        end
        n_cmp++; if (busy !== 3 || tmo) begin n_fail++; $display("FAIL call_busy: got %0d want 3", busy); end
        n_cmp++; if (n_load !== 1 || pcv !== 32'h0000_0200) begin n_fail++; $display("FAIL call_pc: got %0d x %h want 1 x 00000200", n_load, pcv); end
        n_cmp++; if (fmis !== 0) begin n_fail++; $display("FAIL call_flush: got %0d want 0 mismatching cycles", fmis); end
        n_cmp++; if (sp !== 20'hFFFFD) begin n_fail++; $display("FAIL call_sp: got %h want FFFFD", sp); end

        model_op(5'd21, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000);
        issue(5'd21, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000);
        observe(busy, n_load, pcv, n_fl, flv, n_ack, fmis, tmo);
        want[0] = {20'hFFFFE, 1'b0, 16'h0};
        want[1] = {20'hFFFFF, 1'b0, 16'h0};
        n_cmp++; if (acc_log.size() != 2) begin n_fail++; $display("FAIL ret_nacc: got %0d want 2", acc_log.size()); end
        for (int i = 0; i < 2; i++) begin
            n_cmp++; if (i >= acc_log.size() || acc_log[i] !== want[i]) begin n_fail++; $display("FAIL ret_acc%0d: got %h want %h", i, (i < acc_log.size()) ? acc_log[i] : '0, want[i]); end
        end
        n_cmp++; if (busy !== 3 || tmo) begin n_fail++; $display("FAIL ret_busy: got %0d want 3", busy); end
        n_cmp++; if (pcv !== 32'h0001_0004 || n_fl !== 0) begin n_fail++; $display("FAIL ret_pc: got %h fl %0d want 00010004 fl 0", pcv, n_fl); end
        n_cmp++; if (sp !== 20'hFFFFF) begin n_fail++; $display("FAIL ret_sp: got %h want FFFFF", sp); end
    endtask

    task automatic test_wait_states();
        ack_delay = 3;
        unstable = 0;
        model_op(5'd20, 1'b1, 1'b0, 1'b0, 32'hCAFE_0100, 32'hBEEF_0042, 32'h0, 3'b000);
        issue(5'd20, 1'b1, 1'b0, 1'b0, 32'hCAFE_0100, 32'hBEEF_0042, 32'h0, 3'b000);
        observe(busy, n_load, pcv, n_fl, flv, n_ack, fmis, tmo);
        n_cmp++; if (busy !== 9 || tmo) begin n_fail++; $display("FAIL wcall_busy: got %0d want 9", busy); end
        n_cmp++; if (acc_log.size() != 2 || acc_log[0] !== exp_log[0] || acc_log[1] !== exp_log[1]) begin n_fail++; $display("FAIL wcall_acc: got %0d accesses, want %h %h", acc_log.size(), exp_log[0], exp_log[1]); end
        n_cmp++; if (pcv !== 32'hCAFE_0100) begin n_fail++; $display("FAIL wcall_pc: got %h want CAFE0100", pcv); end
        model_op(5'd21, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000);
        issue(5'd21, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000);
        observe(busy, n_load, pcv, n_fl, flv, n_ack, fmis, tmo);
        n_cmp++; if (busy !== 9 || tmo) begin n_fail++; $display("FAIL wret_busy: got %0d want 9", busy); end
        n_cmp++; if (pcv !== 32'hBEEF_0042 || sp !== SP_INIT) begin n_fail++; $display("FAIL wret_pc: got %h sp %h want BEEF0042 sp FFFFF", pcv, sp); end
        n_cmp++; if (unstable !== 0) begin n_fail++; $display("FAIL wait_stable: got %0d changes want 0", unstable); end
        ack_delay = 0;
    endtask

    task automatic test_interrupt();
        acc_t want [3];
        int held;
        ack_delay = 0;
        model_op(5'd20, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0000_0304, 32'h1234_5678, 3'b101);
        issue(5'd20, 1'b1, 1'b0, 1'b1, 32'h0000_0300, 32'h0000_0304, 32'h1234_5678, 3'b101);
        observe(busy, n_load, pcv, n_fl, flv, n_ack, fmis, tmo);
        want[0] = {20'hFFFFF, 1'b1, 16'h0005};
        want[1] = {20'hFFFFE, 1'b1, 16'h1234};
        want[2] = {20'hFFFFD, 1'b1, 16'h5678};
        n_cmp++; if (acc_log.size() != 3) begin n_fail++; $display("FAIL int_nacc: got %0d want 3", acc_log.size()); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (i >= acc_log.size() || acc_log[i] !== want[i]) begin n_fail++; $display("FAIL int_acc%0d: got %h want %h", i, (i < acc_log.size()) ? acc_log[i] : '0, want[i]); end
        end
        n_cmp++; if (busy !== 4 || tmo) begin n_fail++; $display("FAIL int_busy: got %0d want 4", busy); end
        n_cmp++; if (pcv !== INT_VEC || n_ack !== 1) begin n_fail++; $display("FAIL int_vec: got %h ack %0d want %h ack 1", pcv, n_ack, INT_VEC); end
        n_cmp++; if (int_en !== 1'b0 || sp !== 20'hFFFFC) begin n_fail++; $display("FAIL int_state: got en %b sp %h want en 0 sp FFFFC", int_en, sp); end

        // A second request must be held off while interrupts are disabled.
        acc_log.delete();
        held = 0;
        @(negedge clk);
        int_req = 1'b1;
        repeat (6) begin @(negedge clk); if (stall) held++; end
        int_req = 1'b0;
        n_cmp++; if (held !== 0 || acc_log.size() != 0) begin n_fail++; $display("FAIL int_blocked: got %0d busy cycles want 0", held); end

        model_op(5'd22, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000);
        issue(5'd22, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000);
        observe(busy, n_load, pcv, n_fl, flv, n_ack, fmis, tmo);
        n_cmp++; if (busy !== 4 || tmo) begin n_fail++; $display("FAIL reti_busy: got %0d want 4", busy); end
        n_cmp++; if (pcv !== 32'h1234_5678) begin n_fail++; $display("FAIL reti_pc: got %h want 12345678", pcv); end
        n_cmp++; if (n_fl !== 1 || flv !== 3'b101) begin n_fail++; $display("FAIL reti_flags: got %0d x %b want 1 x 101", n_fl, flv); end
        n_cmp++; if (int_en !== 1'b1 || sp !== SP_INIT || n_ack !== 0) begin n_fail++; $display("FAIL reti_state: got en %b sp %h ack %0d want 1 FFFFF 0", int_en, sp, n_ack); end
    endtask

    task automatic test_kill_wrap();
        ack_delay = 0;
        issue(5'd20, 1'b1, 1'b1, 1'b0, 32'h0000_0700, 32'h0000_0704, 32'h0, 3'b000);
        observe(busy, n_load, pcv, n_fl, flv, n_ack, fmis, tmo);
        n_cmp++; if (busy !== 0 || acc_log.size() != 0 || sp !== SP_INIT) begin n_fail++; $display("FAIL kill: got busy %0d acc %0d sp %h want 0 0 FFFFF", busy, acc_log.size(), sp); end
        issue(5'd7, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000);
        observe(busy, n_load, pcv, n_fl, flv, n_ack, fmis, tmo);
        n_cmp++; if (busy !== 0 || acc_log.size() != 0) begin n_fail++; $display("FAIL other_op: got busy %0d acc %0d want 0 0", busy, acc_log.size()); end

        // RET from FFFFF reads wrapped addresses 00000/00001, CALL then pushes through 00000.
        model_op(5'd21, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000);
        issue(5'd21, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 3'b000);
        observe(busy, n_load, pcv, n_fl, flv, n_ack, fmis, tmo);
        n_cmp++; if (acc_log.size() != 2 || acc_log[0].addr !== 20'h00000 || sp !== 20'h00001) begin n_fail++; $display("FAIL wrap_pop: got %0d acc sp %h want first 00000 sp 00001", acc_log.size(), sp); end
        n_cmp++; if (pcv !== e_pc) begin n_fail++; $display("FAIL wrap_pop_pc: got %h want %h", pcv, e_pc); end
        model_op(5'd20, 1'b1, 1'b0, 1'b0, 32'h0000_0900, 32'hAAAA_5555, 32'h0, 3'b000);
        issue(5'd20, 1'b1, 1'b0, 1'b0, 32'h0000_0900, 32'hAAAA_5555, 32'h0, 3'b000);
        observe(busy, n_load, pcv, n_fl, flv, n_ack, fmis, tmo);
        n_cmp++; if (acc_log.size() != 2 || acc_log[1] !== {20'h00000, 1'b1, 16'h5555}) begin n_fail++; $display("FAIL wrap_push: got %0d accesses want last 00000<=5555", acc_log.size()); end
        n_cmp++; if (sp !== 20'hFFFFF) begin n_fail++; $display("FAIL wrap_sp: got %h want FFFFF", sp); end
    endtask

    task automatic test_random();
        logic [4:0] op;
        bit valid, kl, irq;
        logic [31:0] tgt, ret, iret;
        logic [2:0] fl;
        int r;
        unstable = 0;
        spur_en = 1'b1;
        for (int it = 0; it < 60; it++) begin
            r = $urandom_range(0, 9);
            op = (r < 3) ? 5'd20 : (r < 6) ? 5'd21 : (r < 8) ? 5'd22 : 5'($urandom_range(0, 19));
            valid = ($urandom_range(0, 7) != 0);
            kl = ($urandom_range(0, 5) == 0);
            irq = ($urandom_range(0, 4) == 0);
            tgt = $urandom; ret = $urandom; iret = $urandom; fl = 3'($urandom);
            ack_delay = $urandom_range(0, 2);
            model_op(op, valid, kl, irq, tgt, ret, iret, fl);
            issue(op, valid, kl, irq, tgt, ret, iret, fl);
            observe(busy, n_load, pcv, n_fl, flv, n_ack, fmis, tmo);
            n_cmp++; if (busy !== e_busy || tmo) begin n_fail++; $display("FAIL rnd%0d_busy: got %0d want %0d", it, busy, e_busy); end
            n_cmp++; if (acc_log.size() != exp_log.size()) begin n_fail++; $display("FAIL rnd%0d_nacc: got %0d want %0d", it, acc_log.size(), exp_log.size()); end
            for (int i = 0; i < exp_log.size(); i++) begin
                n_cmp++; if (i >= acc_log.size() || acc_log[i] !== exp_log[i]) begin n_fail++; $display("FAIL rnd%0d_acc%0d: got %h want %h", it, i, (i < acc_log.size()) ? acc_log[i] : '0, exp_log[i]); end
            end
            n_cmp++; if (n_load !== int'(e_acc) || (e_acc && pcv !== e_pc)) begin n_fail++; $display("FAIL rnd%0d_pc: got %0d x %h want %0d x %h", it, n_load, pcv, e_acc, e_pc); end
            n_cmp++; if (n_fl !== int'(e_fload) || (e_fload && flv !== e_flags)) begin n_fail++; $display("FAIL rnd%0d_flags: got %0d x %b want %0d x %b", it, n_fl, flv, e_fload, e_flags); end
            n_cmp++; if (n_ack !== int'(e_iack) || fmis !== 0) begin n_fail++; $display("FAIL rnd%0d_ack: got ack %0d flushmis %0d want %0d 0", it, n_ack, fmis, e_iack); end
            n_cmp++; if (sp !== m_sp || int_en !== m_int_en) begin n_fail++; $display("FAIL rnd%0d_state: got sp %h en %b want %h %b", it, sp, int_en, m_sp, m_int_en); end
        end
        n_cmp++; if (unstable !== 0) begin n_fail++; $display("FAIL rnd_stable: got %0d changes want 0", unstable); end
        spur_en = 1'b0;
        ack_delay = 0;
    endtask

    task automatic test_reset_mid();
        ack_delay = 0;
        model_op(5'd0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0000_4444, 3'b011);
        issue(5'd0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0, 32'h0000_4444, 3'b011);
        observe(busy, n_load, pcv, n_fl, flv, n_ack, fmis, tmo);
        ack_delay = 50;
        issue(5'd20, 1'b1, 1'b0, 1'b0, 32'h0000_0A00, 32'h0000_0A04, 32'h0, 3'b000);
        repeat (2) @(negedge clk);
        n_cmp++; if (bus.mem_req !== 1'b1 || bus.mem_we !== 1'b1 || stall !== 1'b1) begin n_fail++; $display("FAIL mid_busy: got req %b we %b stall %b want 1 1 1", bus.mem_req, bus.mem_we, stall); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.mem_req !== 1'b0 || stall !== 1'b0) begin n_fail++; $display("FAIL mid_rst_req: got req %b stall %b want 0 0", bus.mem_req, stall); end
        n_cmp++; if (sp !== SP_INIT || int_en !== 1'b1) begin n_fail++; $display("FAIL mid_rst_state: got sp %h en %b want FFFFF 1", sp, int_en); end
        @(negedge clk);
        rst_n = 1'b1;
        m_sp = SP_INIT; m_int_en = 1'b1;
        ack_delay = 0;
        model_op(5'd20, 1'b1, 1'b0, 1'b0, 32'h0000_0B00, 32'h0000_0B04, 32'h0, 3'b000);
        issue(5'd20, 1'b1, 1'b0, 1'b0, 32'h0000_0B00, 32'h0000_0B04, 32'h0, 3'b000);
        observe(busy, n_load, pcv, n_fl, flv, n_ack, fmis, tmo);
        n_cmp++; if (busy !== 3 || acc_log.size() != 2 || acc_log[0].addr !== SP_INIT || pcv !== 32'h0000_0B00) begin n_fail++; $display("FAIL post_rst_call: got busy %0d acc %0d pc %h want 3 2 00000B00", busy, acc_log.size(), pcv); end
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        test_reset();
        test_call_ret();
        test_wait_states();
        test_interrupt();
        test_kill_wrap();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
